// File: rtl/pll_sup_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pll_sup_pkg                                                      |
// | Purpose  : Shared state encodings and sizing helpers for the PLL lock       |
// |            supervisor and its status CSR decoder.                           |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package pll_sup_pkg;

  localparam int STATE_W = 3;

  // Encodings are fixed; the status CSR decoder depends on these values.
  typedef enum logic [STATE_W-1:0] {
    PLL_RESET = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;

  // Bits needed to hold 0 .. terminal-1 (never less than one bit).
  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : sync_2ff                                                         |
// | Purpose  : 1-bit double-flop synchroniser, asynchronous reset to 0.         |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  // Two back-to-back flops; the first may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : pll_lock_supervisor                                              |
// | Purpose  : Sequences the PLL reset, qualifies lock for stability, releases  |
// |            the downstream reset, re-locks on loss and faults after repeated |
// |            lock timeouts.                                                   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RETRY_LIMIT         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic [7:0] relock_count
);

  import pll_sup_pkg::*;

  // One timer is shared by PLL_RESET, WAIT_LOCK and STABLE, so size it for the longest.
  localparam int TIMER_W = cnt_width(max3(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES));
  localparam int RETRY_W = cnt_width(RETRY_LIMIT + 1);

  localparam logic [TIMER_W-1:0] C_RST_LAST = TIMER_W'(PLL_RST_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_TO_LAST  = TIMER_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] C_STB_LAST = TIMER_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] C_RETRY_MAX = RETRY_W'(RETRY_LIMIT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [TIMER_W-1:0] r_timer;
  logic [TIMER_W-1:0] w_timer_inc;
  logic [TIMER_W-1:0] w_timer_nxt;
  logic [RETRY_W-1:0] r_retry;
  logic [RETRY_W-1:0] w_retry_nxt;
  logic [7:0]         r_relock;
  logic [7:0]         w_relock_nxt;
  logic               w_locked_s;
  logic               r_pll_rst;
  logic               r_sys_rst;
  logic               r_ready;
  logic               r_fault;

  sync_2ff u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (pll_locked),
    .q   (w_locked_s)
  );

  // Next-state, timer, retry and relock decisions; restart overrides everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_timer_inc  = r_timer + 1'b1;
    w_timer_nxt  = w_timer_inc;
    w_retry_nxt  = r_retry;
    w_relock_nxt = r_relock;
    if (restart) begin
      w_state_nxt = PLL_RESET;
      w_timer_nxt = '0;
      w_retry_nxt = '0;
    end else begin
      case (r_state)
        PLL_RESET: begin
          if (r_timer == C_RST_LAST) begin
            w_state_nxt = WAIT_LOCK;
            w_timer_nxt = '0;
          end
        end
        WAIT_LOCK: begin
          if (w_locked_s) begin
            w_state_nxt = STABLE;
            w_timer_nxt = '0;
          end else if (r_timer == C_TO_LAST) begin
            w_retry_nxt = r_retry + 1'b1;
            w_state_nxt = (w_retry_nxt == C_RETRY_MAX) ? FAULT : PLL_RESET;
            w_timer_nxt = '0;
          end
        end
        STABLE: begin
          // The WAIT_LOCK exit edge already consumed one locked sample, so the
          // count is complete once the incremented value reaches the last index.
          if (!w_locked_s) begin
            w_state_nxt = WAIT_LOCK;
            w_timer_nxt = '0;
          end else if (w_timer_inc >= C_STB_LAST) begin
            w_state_nxt = RUN;
            w_timer_nxt = '0;
            w_retry_nxt = '0;
          end
        end
        RUN: begin
          w_timer_nxt = '0;
          if (!w_locked_s) begin
            w_state_nxt = PLL_RESET;
            if (r_relock != 8'hFF) begin
              w_relock_nxt = r_relock + 8'd1;
            end
          end
        end
        FAULT: begin
          w_timer_nxt = '0;
        end
        default: begin
          w_state_nxt = PLL_RESET;
          w_timer_nxt = '0;
        end
      endcase
    end
  end

  // State register plus outputs decoded from the next state so they switch with it.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      r_state   <= PLL_RESET;
      r_timer   <= '0;
      r_retry   <= '0;
      r_relock  <= 8'd0;
      r_pll_rst <= 1'b1;
      r_sys_rst <= 1'b1;
      r_ready   <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timer   <= w_timer_nxt;
      r_retry   <= w_retry_nxt;
      r_relock  <= w_relock_nxt;
      r_pll_rst <= (w_state_nxt == PLL_RESET) || (w_state_nxt == FAULT);
      r_sys_rst <= (w_state_nxt != RUN);
      r_ready   <= (w_state_nxt == RUN);
      r_fault   <= (w_state_nxt == FAULT);
    end
  end

  assign pll_rst      = r_pll_rst;
  assign sys_rst      = r_sys_rst;
  assign ready        = r_ready;
  assign fault        = r_fault;
  assign relock_count = r_relock;

endmodule
`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_pll_lock_supervisor                                           |
// | Purpose  : Directed scoreboard bench for pll_lock_supervisor.               |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module tb_pll_lock_supervisor;

  localparam int PRC = 4;
  localparam int LTC = 20;
  localparam int LSC = 8;
  localparam int RL  = 3;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       restart;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic [7:0] relock_count;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // Scoreboard: absolute cycle, expected {pll_rst,sys_rst,ready,fault,relock_count}, name.
  int          sb_cyc[$];
  logic [11:0] sb_val[$];
  string       sb_name[$];

  pll_lock_supervisor #(
    .PLL_RST_CYCLES      (PRC),
    .LOCK_TIMEOUT_CYCLES (LTC),
    .LOCK_STABLE_CYCLES  (LSC),
    .RETRY_LIMIT         (RL)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .restart      (restart),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fault        (fault),
    .relock_count (relock_count)
  );

  always #5 refclk = ~refclk;

  // Edge counter; stimulus runs 1 time unit after each edge and sees the updated value.
  always @(posedge refclk) cyc <= cyc + 1;

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  always @(negedge refclk) begin
    logic [11:0] got;
    got = {pll_rst, sys_rst, ready, fault, relock_count};
    while (sb_cyc.size() > 0 && sb_cyc[0] <= cyc) begin
      int          c;
      logic [11:0] e;
      string       n;
      c = sb_cyc.pop_front();
      e = sb_val.pop_front();
      n = sb_name.pop_front();
      checks++;
      if (c != cyc) begin
        errors++;
        $display("FAIL %s: sample for cycle %0d taken at cycle %0d", n, c, cyc);
      end else if (got !== e) begin
        errors++;
        $display("FAIL %s @cyc %0d: got pll_rst/sys_rst/ready/fault=%b relock=%0d, expected %b relock=%0d",
                 n, cyc, got[11:8], got[7:0], e[11:8], e[7:0]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge refclk);
    #1;
  endtask

  // Expect the outputs k edges from now (k=0: the state visible in the current cycle).
  task automatic expect_at(input int k, input string name, input logic p, input logic s,
                           input logic r, input logic f, input logic [7:0] rc);
    sb_cyc.push_back(cyc + k);
    sb_val.push_back({p, s, r, f, rc});
    sb_name.push_back(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    restart    = 1'b0;
    tick(2);
    expect_at(0, "reset_state", 1, 1, 0, 0, 8'd0);
    tick(1);

    // 1. Power-up: 4-cycle pll_rst, lock 3 cycles after release, ready 2+LSC edges after lock.
    rst = 1'b0;
    expect_at(PRC - 1, "pll_rst_held", 1, 1, 0, 0, 8'd0);
    expect_at(PRC,     "pll_rst_fall", 0, 1, 0, 0, 8'd0);
    tick(PRC);
    tick(3);
    pll_locked = 1'b1;
    expect_at(2 + LSC - 1, "ready_not_yet", 0, 1, 0, 0, 8'd0);
    expect_at(2 + LSC,     "ready_rise",    0, 0, 1, 0, 8'd0);
    tick(2 + LSC);

    // 3. Lock loss in RUN: 2 synchroniser edges, then the state edge.
    tick(2);
    pll_locked = 1'b0;
    expect_at(2, "run_before_loss", 0, 0, 1, 0, 8'd0);
    expect_at(3, "lock_loss",       1, 1, 0, 0, 8'd1);
    tick(3);
    expect_at(PRC - 1, "relock_pll_rst", 1, 1, 0, 0, 8'd1);
    expect_at(PRC,     "relock_wait",    0, 1, 0, 0, 8'd1);
    tick(PRC);

    // 2. Re-lock with a 3-cycle glitch mid-STABLE: back to WAIT_LOCK, count restarts.
    pll_locked = 1'b1;
    expect_at(4, "stable_entered", 0, 1, 0, 0, 8'd1);
    tick(5);
    pll_locked = 1'b0;
    expect_at(3, "glitch_to_wait", 0, 1, 0, 0, 8'd1);
    tick(3);
    pll_locked = 1'b1;
    expect_at(2 + LSC - 1, "glitch_ready_late", 0, 1, 0, 0, 8'd1);
    expect_at(2 + LSC,     "glitch_ready_rise", 0, 0, 1, 0, 8'd1);
    tick(2 + LSC);

    // 4. Lock never returns: relock 2, then three pulses each 4 high / 20 low, then FAULT.
    tick(2);
    pll_locked = 1'b0;
    for (int p = 0; p < RL; p++) begin
      int b;
      b = 3 + p * (PRC + LTC);
      expect_at(b,               "pulse_start", 1, 1, 0, 0, 8'd2);
      expect_at(b + PRC - 1,     "pulse_end",   1, 1, 0, 0, 8'd2);
      expect_at(b + PRC,         "pulse_fall",  0, 1, 0, 0, 8'd2);
      expect_at(b + PRC + LTC - 1, "wait_last", 0, 1, 0, 0, 8'd2);
    end
    expect_at(3 + RL * (PRC + LTC),      "fault_set",  1, 1, 0, 1, 8'd2);
    expect_at(3 + RL * (PRC + LTC) + 10, "fault_held", 1, 1, 0, 1, 8'd2);
    tick(3 + RL * (PRC + LTC) + 10);

    // 5. Restart out of FAULT with lock present; relock_count is preserved.
    restart    = 1'b1;
    pll_locked = 1'b1;
    expect_at(1, "restart_clears_fault", 1, 1, 0, 0, 8'd2);
    tick(1);
    restart = 1'b0;
    expect_at(PRC - 1,       "restart_pll_rst",  1, 1, 0, 0, 8'd2);
    expect_at(PRC,           "restart_wait",     0, 1, 0, 0, 8'd2);
    expect_at(PRC + LSC - 1, "restart_not_yet",  0, 1, 0, 0, 8'd2);
    expect_at(PRC + LSC,     "restart_ready",    0, 0, 1, 0, 8'd2);
    tick(PRC + LSC);

    // 6. Asynchronous reset mid-RUN and mid-STABLE, visible before the next edge.
    tick(2);
    rst = 1'b1;
    expect_at(0, "arst_run", 1, 1, 0, 0, 8'd0);
    tick(2);
    expect_at(0, "arst_held", 1, 1, 0, 0, 8'd0);
    rst = 1'b0;
    expect_at(PRC + 2, "stable_after_rst", 0, 1, 0, 0, 8'd0);
    tick(PRC + 3);
    rst = 1'b1;
    expect_at(0, "arst_stable", 1, 1, 0, 0, 8'd0);
    tick(2);
    rst = 1'b0;
    tick(3);

    while (sb_cyc.size() > 0) begin
      string n;
      n = sb_name.pop_front();
      void'(sb_cyc.pop_front());
      void'(sb_val.pop_front());
      checks++;
      errors++;
      $display("FAIL %s: expected sample never taken", n);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
